// File: rtl/sm_hex_display_mux.sv
// rtl/sm_hex_display_mux.sv - time-multiplexed hex 7-segment display driver
//
// Scans DIGITS hex nibbles onto one shared segment bus with one-hot digit
// selects. Each digit slot is DIV cycles long. The first GUARD cycles of each
// slot are blanked to prevent ghosting. The displayed word is captured once per
// frame so that the whole display always shows a single consistent value.
//
// Optional feature: define SM_HEX_DISPLAY_MUX_LZB_EN to enable leading-zero
// blanking. Digit 0 is always shown.
//
// Ports:
//   clkIn        in   clock
//   rst          in   synchronous active-high reset
//   en           in   scan enable; 0 freezes the scan and blanks the display
//   value        in   hex word, digit i = value[4i+3:4i], digit 0 rightmost
//   dp           in   decimal point per digit
//   seg          out  segments {g,f,e,d,c,b,a}
//   seg_dp       out  decimal point segment
//   dig_sel      out  one-hot digit select
//   frame_start  out  one-cycle pulse on the first output cycle of a frame
module sm_hex_display_mux #(
    parameter int DIGITS     = 3,
    parameter int DIV        = 50000,
    parameter int GUARD      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clkIn,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_start
);

    localparam int PW = $clog2(DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PCNT_MAX = PW'(DIV - 1);
    localparam logic [PW-1:0] GUARD_V  = PW'(GUARD);
    localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);

    // Inactive levels for each output group; XOR with these applies polarity.
    localparam logic [6:0]        SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = ACTIVE_LOW;
    localparam logic [DIGITS-1:0] DIG_OFF = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [PW-1:0]       r_pcnt;
    logic [IW-1:0]       r_idx;
    logic [4*DIGITS-1:0] r_shadow_val;
    logic [DIGITS-1:0]   r_shadow_dp;

    logic [6:0]          r_seg;
    logic                r_seg_dp;
    logic [DIGITS-1:0]   r_dig_sel;
    logic                r_frame_start;

    logic [3:0]          w_nib;
    logic                w_dp_bit;
    logic [DIGITS-1:0]   w_onehot;
    logic                w_blank;
    logic [6:0]          w_seg;
    logic                w_active;
    logic                w_frame_head;

    assign w_active     = en && (r_pcnt >= GUARD_V);
    assign w_frame_head = (r_pcnt == '0) && (r_idx == '0);

    // Select the current digit's nibble, decimal point and select bit.
    always_comb begin
        w_nib    = 4'h0;
        w_dp_bit = 1'b0;
        w_onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_nib       = r_shadow_val[4*i +: 4];
                w_dp_bit    = r_shadow_dp[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

`ifdef SM_HEX_DISPLAY_MUX_LZB_EN
    // Walk down from the top digit; a digit is a leading zero while every
    // nibble from it upward is zero. Digit 0 is never considered.
    logic w_upper_zero;
    always_comb begin
        w_blank      = 1'b0;
        w_upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_upper_zero = w_upper_zero && (r_shadow_val[4*i +: 4] == 4'h0);
            if (r_idx == IW'(i)) begin
                w_blank = w_upper_zero;
            end
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_seg = 7'h00;
        case (w_nib)
            4'h0: w_seg = 7'h3F;
            4'h1: w_seg = 7'h06;
            4'h2: w_seg = 7'h5B;
            4'h3: w_seg = 7'h4F;
            4'h4: w_seg = 7'h66;
            4'h5: w_seg = 7'h6D;
            4'h6: w_seg = 7'h7D;
            4'h7: w_seg = 7'h07;
            4'h8: w_seg = 7'h7F;
            4'h9: w_seg = 7'h6F;
            4'hA: w_seg = 7'h77;
            4'hB: w_seg = 7'h7C;
            4'hC: w_seg = 7'h39;
            4'hD: w_seg = 7'h5E;
            4'hE: w_seg = 7'h79;
            4'hF: w_seg = 7'h71;
            default: w_seg = 7'h00;
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (rst) begin
            r_pcnt        <= '0;
            r_idx         <= '0;
            r_shadow_val  <= '0;
            r_shadow_dp   <= '0;
            r_seg         <= SEG_OFF;
            r_seg_dp      <= DP_OFF;
            r_dig_sel     <= DIG_OFF;
            r_frame_start <= 1'b0;
        end else begin
            if (en) begin
                // The shadow load coincides with pcnt==0, which is always in the
                // guard window, so a freshly loaded value is never shown stale.
                if (w_frame_head) begin
                    r_shadow_val <= value;
                    r_shadow_dp  <= dp;
                end
                if (r_pcnt == PCNT_MAX) begin
                    r_pcnt <= '0;
                    r_idx  <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
                end else begin
                    r_pcnt <= r_pcnt + 1'b1;
                end
            end

            r_seg         <= (w_active && !w_blank) ? (w_seg ^ SEG_OFF) : SEG_OFF;
            r_seg_dp      <= w_active ? (w_dp_bit ^ DP_OFF) : DP_OFF;
            r_dig_sel     <= w_active ? (w_onehot ^ DIG_OFF) : DIG_OFF;
            r_frame_start <= en && w_frame_head;
        end
    end

    assign seg         = r_seg;
    assign seg_dp      = r_seg_dp;
    assign dig_sel     = r_dig_sel;
    assign frame_start = r_frame_start;

endmodule
